// File: rtl/alu_pkg.sv
// alu_pkg: shared divider state encoding, counter width and width-generic constant patterns
package alu_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;
  localparam int DIV_XLEN = 64;
  localparam int DIV_CNT_W = $clog2(DIV_XLEN);
  function automatic logic [DIV_XLEN-1:0] all_ones(input int xlen);
    return {DIV_XLEN{1'b1}} >> (DIV_XLEN - xlen);
  endfunction
  function automatic logic [DIV_XLEN-1:0] most_neg(input int xlen);
    return {{(DIV_XLEN-1){1'b0}}, 1'b1} << (xlen - 1);
  endfunction
endpackage

// File: rtl/div_addsub_step.sv
// div_addsub_step: one non-restoring step, adds b when neg is set, otherwise subtracts it
module div_addsub_step #(
  parameter int W = 65
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         neg,
  output logic [W-1:0] y
);
  // Subtract as invert-plus-carry-in so a single carry-lookahead adder serves both directions
  assign y = a + (b ^ {W{~neg}}) + {{(W-1){1'b0}}, ~neg};
endmodule

// File: rtl/div_iter_unit.sv
// div_iter_unit: radix-2 non-restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle
module div_iter_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam logic [XLEN-1:0] ONES = XLEN'(all_ones(XLEN));
  localparam logic [XLEN-1:0] MOST_NEG = XLEN'(most_neg(XLEN));
  div_state_e state, state_nx;
  logic [XLEN:0] rem, step_a, step_y;
  logic [XLEN-1:0] quo, dvs, mag_a, mag_b, fix_rem;
  logic [DIV_CNT_W-1:0] cnt;
  logic sign_q, sign_r, neg_a, neg_b, div_zero, ovf;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign quotient = quo;
  assign remainder = rem[XLEN-1:0];
  assign neg_a = is_signed && dividend[XLEN-1];
  assign neg_b = is_signed && divisor[XLEN-1];
  assign mag_a = neg_a ? -dividend : dividend;
  assign mag_b = neg_b ? -divisor : divisor;
  assign div_zero = divisor == '0;
  assign ovf = is_signed && dividend == MOST_NEG && divisor == ONES;
  // The quotient register doubles as the dividend shifter feeding the partial remainder
  assign step_a = state == CALC ? {rem[XLEN-1:0], quo[XLEN-1]} : rem;
  div_addsub_step #(.W(XLEN + 1)) u_step (
    .a  (step_a),
    .b  ({1'b0, dvs}),
    .neg(rem[XLEN]),
    .y  (step_y)
  );
  assign fix_rem = rem[XLEN] ? step_y[XLEN-1:0] : rem[XLEN-1:0];
  always_comb begin
    state_nx = state;
    state_nx = flush ? IDLE :
               state == IDLE ? (in_valid ? ((div_zero || ovf) ? DONE : CALC) : IDLE) :
               state == CALC ? (cnt == '0 ? FIX : CALC) :
               state == FIX  ? DONE :
               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= IDLE;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        dvs <= mag_b;
        sign_q <= neg_a ^ neg_b;
        sign_r <= neg_a;
        cnt <= DIV_CNT_W'(XLEN - 1);
        quo <= div_zero ? ONES : ovf ? dividend : mag_a;
        rem <= div_zero ? {1'b0, dividend} : '0;
      end else if (state == CALC) begin
        rem <= step_y;
        quo <= {quo[XLEN-2:0], ~step_y[XLEN]};
        cnt <= cnt - DIV_CNT_W'(1);
      end else if (state == FIX) begin
        rem <= {1'b0, sign_r ? -fix_rem : fix_rem};
        quo <= sign_q ? -quo : quo;
      end
    end
  end
endmodule

// File: tb/tb_div_iter_unit.sv
// tb_div_iter_unit: directed vector table, random ops against an arithmetic model, flush/reset sequences
module tb_div_iter_unit;
  localparam int XLEN = 64;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, is_signed = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [63:0] dividend = 0, divisor = 0, quotient, remainder;
  int checks = 0, failures = 0;
  typedef struct {
    logic [63:0] a, b;
    logic s;
    int hold;
    logic [63:0] q, r;
    int lat;
  } vec_t;
  vec_t tv[11];
  always #5 clk = ~clk;
  div_iter_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient), .remainder(remainder)
  );
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  function automatic void ref_div(input logic [63:0] a, b, input logic s,
                                  output logic [63:0] q, r, output int lat);
    longint sa, sb;
    sa = a;
    sb = b;
    lat = XLEN + 2;
    if (b == 0) begin q = ALL; r = a; lat = 1; end
    else if (s && a == MIN && b == ALL) begin q = a; r = 0; lat = 1; end
    else if (s) begin q = sa / sb; r = sa % sb; end
    else begin q = a / b; r = a % b; end
  endfunction
  task automatic run_op(input string tag, input logic [63:0] a, b, input logic s, input int hold,
                        input logic [63:0] q, r, input int lat_exp);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready_idle"}, in_ready, 1);
    dividend = a; divisor = b; is_signed = s; in_valid = 1; out_ready = (hold == 0);
    @(posedge clk);
    #1 in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
    check({tag, "_quotient"}, quotient, q);
    check({tag, "_remainder"}, remainder, r);
    repeat (hold) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, {out_valid, in_ready}, 64'b10);
      check({tag, "_hold_q"}, quotient, q);
      check({tag, "_hold_r"}, remainder, r);
    end
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    check({tag, "_after_handshake"}, {out_valid, in_ready}, 64'b01);
  endtask
  task automatic start_op(input logic [63:0] a, b, input logic s);
    @(negedge clk);
    dividend = a; divisor = b; is_signed = s; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  initial begin
    logic [63:0] a, b, q, r;
    logic s;
    int lat, seen;
    tv[0]  = '{64'd100, 64'd7, 1'b0, 0, 64'd14, 64'd2, 66};
    tv[1]  = '{-64'sd7, 64'd2, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFD, ALL, 66};
    tv[2]  = '{64'd7, -64'sd2, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66};
    tv[3]  = '{64'd5, 64'd0, 1'b0, 0, ALL, 64'd5, 1};
    tv[4]  = '{-64'sd5, 64'd0, 1'b1, 0, ALL, 64'hFFFF_FFFF_FFFF_FFFB, 1};
    tv[5]  = '{MIN, ALL, 1'b1, 0, MIN, 64'd0, 1};
    tv[6]  = '{MIN, ALL, 1'b0, 0, 64'd0, MIN, 66};
    tv[7]  = '{64'd1000, 64'd10, 1'b0, 20, 64'd100, 64'd0, 66};
    tv[8]  = '{-64'sd8, -64'sd3, 1'b1, 0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 66};
    tv[9]  = '{ALL, 64'd1, 1'b0, 3, ALL, 64'd0, 66};
    tv[10] = '{MIN, 64'd3, 1'b1, 0, 64'hD555_5555_5555_5556, 64'hFFFF_FFFF_FFFF_FFFE, 66};
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready_valid", {in_ready, out_valid}, 64'b10);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    rst = 0;
    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), tv[i].a, tv[i].b, tv[i].s, tv[i].hold, tv[i].q, tv[i].r, tv[i].lat);
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = 64'($urandom_range(1, 20));
        2: b = ALL;
        3: a = MIN;
        4: b = b >> $urandom_range(1, 62);
        default: ;
      endcase
      ref_div(a, b, s, q, r, lat);
      run_op($sformatf("rand%0d", i), a, b, s, 0, q, r, lat);
    end
    start_op(64'd1000, 64'd7, 1'b0);
    repeat (33) @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    check("flush_calc_state", {in_ready, out_valid}, 64'b10);
    check("flush_calc_results", {quotient ^ remainder}, 0);
    @(negedge clk);
    in_valid = 1; flush = 1; dividend = 64'd9; divisor = 64'd3; is_signed = 0;
    @(posedge clk);
    #1 in_valid = 0; flush = 0;
    check("flush_drops_in_valid", in_ready, 1);
    start_op(64'd77, 64'd5, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    check("rst_calc_state", {in_ready, out_valid}, 64'b10);
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    check("no_valid_after_abort", 64'(seen), 0);
    run_op("post_abort", 64'd9, 64'd3, 1'b0, 0, 64'd3, 64'd0, 66);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
